// File: rtl/red_pitaya_pwm_gen_if.sv
// red_pitaya_pwm_gen_if: config word in, PWM bit and frame strobes out.
interface red_pitaya_pwm_gen_if #(parameter int CCW = 24);
  logic [CCW-1:0] cfg_i;
  logic pwm_o;
  logic period_o;
  logic frame_o;
  logic cfg_ld_o;
  modport master(output cfg_i, input pwm_o, period_o, frame_o, cfg_ld_o);
  modport slave(input cfg_i, output pwm_o, period_o, frame_o, cfg_ld_o);
endinterface

// File: rtl/red_pitaya_pwm_gen.sv
// red_pitaya_pwm_gen: 256-cycle PWM with 16-period dither; PWM_FRAME_LATCH_EN restricts config loads to frame ends.
module red_pitaya_pwm_gen #(
  parameter int CCW = 24
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  red_pitaya_pwm_gen_if.slave bus
);
  logic [7:0]  cnt;
  logic [3:0]  idx;
  logic [7:0]  duty_s;
  logic [15:0] seq_s;
  logic [8:0]  thr;
  logic        ld;
  assign bus.period_o = cnt == 8'hff;
  assign bus.frame_o  = bus.period_o && idx == 4'hf;
`ifdef PWM_FRAME_LATCH_EN
  assign ld = bus.frame_o;
`else
  assign ld = bus.period_o;
`endif
  assign bus.cfg_ld_o = ld;
  assign thr = {1'b0, duty_s} + {8'd0, seq_s[idx]};
  // a load at cnt==255 lands together with the idx step, so the new config starts cleanly at cnt==0
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt       <= '0;
      idx       <= '0;
      duty_s    <= '0;
      seq_s     <= '0;
      bus.pwm_o <= 1'b0;
    end else begin
      cnt       <= cnt + 8'd1;
      bus.pwm_o <= {1'b0, cnt} < thr;
      if (bus.period_o) idx <= idx + 4'd1;
      if (ld) {duty_s, seq_s} <= bus.cfg_i[CCW-1:0];
    end
  end
endmodule

// File: doc/red_pitaya_pwm_gen.md
RED_PITAYA_PWM_GEN -- requirements
Module: red_pitaya_pwm_gen

Interface
REQ-001 Parameter: CCW, default 24, configuration word width; only 24 is supported.
REQ-002 clk_i  input  1  PWM clock, nominally 250 MHz; the only clock in the block.
REQ-003 rstn_i  input  1  Reset, asynchronous assert, active-low.
REQ-004 cfg_i  input  24  Config word: [23:16] = base duty D (unsigned, 0..255); [15:0] = dither sequence B.
REQ-005 pwm_o  output  1  Registered PWM output bit.
REQ-006 period_o  output  1  One-cycle strobe marking the last cycle of each 256-cycle PWM period.
REQ-007 frame_o  output  1  One-cycle strobe marking the last cycle of each 16-period dither frame.
REQ-008 cfg_ld_o  output  1  One-cycle strobe; high in the cycle whose rising edge loads cfg_i into the shadow register.

Function
REQ-009 8-bit period counter cnt SHALL increment every clock and wrap from 255 to 0; no stall or hold.
REQ-010 4-bit dither index idx SHALL increment on the edge where cnt wraps 255->0, and wrap from 15 to 0.
REQ-011 Shadow registers duty_s (8 bit) and seq_s (16 bit) SHALL hold the active config; pwm logic never reads cfg_i directly.
REQ-012 Threshold thr = {1'b0,duty_s} + seq_s[idx], 9 bit unsigned; no saturation needed (max 256).
REQ-013 pwm_o SHALL be registered: pwm_o <= ({1'b0,cnt} < thr), so pwm_o lags the counter by one clock.
REQ-014 Per period, pwm_o high for exactly thr cycles: D=0,B bit=0 -> never high; D=255,B bit=1 -> high all 256 cycles.
REQ-015 Sequence bit order: period with idx=k uses seq_s[k], bit 0 first.
REQ-016 period_o SHALL be high when cnt==255.
REQ-017 frame_o SHALL be high when cnt==255 and idx==15.
REQ-018 Shadow load SHALL occur only at a boundary (see REQ-024); cfg_i changes at any other time have no effect on the current period.
REQ-019 A cfg_i value held only between boundaries is never applied; cfg_i is sampled at the load edge only.
REQ-020 New shadow value SHALL take effect in the period starting at the next cnt==0.

Reset
REQ-021 While rstn_i low: cnt=0, idx=0, duty_s=0, seq_s=0, pwm_o=0, period_o=0, frame_o=0, cfg_ld_o=0, applied immediately without waiting for a clock.
REQ-022 Reset mid-period SHALL force pwm_o low immediately and discard the partial period.
REQ-023 After release, the first period runs with the zero shadow value, so pwm_o stays low until the first load takes effect.

Configuration
REQ-024 Macro PWM_FRAME_LATCH_EN: defined -> shadow load and cfg_ld_o only when frame_o is high (every 4096 cycles), so the full 16-period dither sequence always completes; undefined -> load and cfg_ld_o whenever period_o is high (every 256 cycles).

Verification
REQ-025 cfg_i=24'h80_0000 held -> pwm_o high 128 consecutive cycles and low 128 cycles in every period after the first load.
REQ-026 cfg_i=24'h00_0000 -> pwm_o never high; cfg_i=24'hFF_FFFF -> pwm_o constantly high after the first load.
REQ-027 cfg_i=24'h40_5555 -> periods with even idx high 65 cycles, odd idx high 64; 1032 high cycles per frame.
REQ-028 cfg_i changed 24'h20_0000->24'hC0_0000 at cnt=100:
- Current period keeps 32 high cycles.
- Macro undefined: next period has 192 high cycles.
- Macro defined: change takes effect only after the next frame_o.
REQ-029 rstn_i asserted at cnt=150 with pwm_o high -> pwm_o low before the next clock edge, all strobes 0; after release, the first 256 cycles are low.
REQ-030 Free run of 8192 cycles -> period_o pulses 32 times, frame_o pulses 2 times, and each frame_o coincides with a period_o.
